// File: rtl/arbitro_registro_if.sv
// Request/grant bus between the requesters and the round-robin register arbiter.
// The master side drives requests and data; the slave side returns grant status.
interface arbitro_registro_if #(
    parameter int W = 8
);
    logic [3:0]     req;
    logic [4*W-1:0] din;
    logic [3:0]     gnt;
    logic [3:0]     ack;
    logic           carga;
    logic [W-1:0]   q;
    logic [1:0]     owner;
    logic           busy;

    modport master (
        output req, din,
        input  gnt, ack, carga, q, owner, busy
    );

    modport slave (
        input  req, din,
        output gnt, ack, carga, q, owner, busy
    );
endinterface

// File: rtl/arbitro_registro.sv
// Four-requester round-robin arbiter that loads the winner's data word into a shared
// register through a fixed IDLE -> GRANT -> LOAD -> DONE handshake.
module arbitro_registro #(
    parameter int W = 8
) (
    input  logic              clk,
    input  logic              reset,
    arbitro_registro_if.slave bus
);
    localparam int N = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        LOAD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t       r_state;
    state_t       w_state_next;
    logic [1:0]   r_owner;
    logic [1:0]   w_owner_next;
    logic [1:0]   r_ptr;
    logic [W-1:0] r_q;
    logic [1:0]   w_winner;
    logic [1:0]   w_idx;
    logic [N-1:0] w_owner_onehot;

    // Scan from the highest offset down so the request nearest to r_ptr is written last.
    always_comb begin
        w_winner = r_ptr;
        w_idx    = r_ptr;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = r_ptr + 2'(k);
            if (bus.req[w_idx]) begin
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_owner_next = r_owner;
        case (r_state)
            IDLE: begin
                if (|bus.req) begin
                    w_owner_next = w_winner;
                    w_state_next = GRANT;
                end
            end
            GRANT: begin
                if (bus.req[r_owner]) begin
                    w_state_next = LOAD;
                end else begin
                    w_state_next = IDLE;
                end
            end
            LOAD:    w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_owner <= 2'd0;
            r_ptr   <= 2'd0;
            r_q     <= '0;
        end else begin
            r_state <= w_state_next;
            r_owner <= w_owner_next;
            if (r_state == LOAD) begin
                r_q <= bus.din[r_owner*W +: W];
            end
            // An aborted grant returns through GRANT -> IDLE and leaves the pointer alone.
            if (r_state == DONE) begin
                r_ptr <= r_owner + 2'd1;
            end
        end
    end

    // Outputs depend only on registered state and owner, never on req or din.
    assign w_owner_onehot = N'(4'b0001 << r_owner);
    assign bus.gnt   = ((r_state == GRANT) || (r_state == LOAD)) ? w_owner_onehot : '0;
    assign bus.ack   = (r_state == DONE) ? w_owner_onehot : '0;
    assign bus.carga = (r_state == LOAD);
    assign bus.busy  = (r_state != IDLE);
    assign bus.q     = r_q;
    assign bus.owner = r_owner;
endmodule

// File: tb/tb_arbitro_registro.sv
// Directed bench for arbitro_registro: single transfer, round-robin fairness, abort,
// asynchronous reset during LOAD, late request and idle stability.
module tb_arbitro_registro;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    arbitro_registro_if #(.W(8)) bus ();

    arbitro_registro #(.W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    logic [1:0] exp_owner [5];
    logic [7:0] exp_q     [5];

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        exp_owner = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_q     = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        reset     = 1'b1;
        bus.req   = 4'b0000;
        bus.din   = 32'h0;

        // Reset state
        tick(); tick();
        chk("rst_q", 32'(bus.q), 32'h00);
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_ack", 32'(bus.ack), 32'h0);
        chk("rst_carga", 32'(bus.carga), 32'h0);
        chk("rst_owner", 32'(bus.owner), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        reset = 1'b0;
        tick();
        $display("step reset: done");

        // Single transfer from requester 0
        bus.din = 32'h332211A5;
        bus.req = 4'b0001;
        tick();
        chk("single_gnt1", 32'(bus.gnt), 32'h1);
        chk("single_busy", 32'(bus.busy), 32'h1);
        chk("single_carga0", 32'(bus.carga), 32'h0);
        tick();
        chk("single_gnt2", 32'(bus.gnt), 32'h1);
        chk("single_carga1", 32'(bus.carga), 32'h1);
        chk("single_q_hold", 32'(bus.q), 32'h00);
        tick();
        chk("single_ack", 32'(bus.ack), 32'h1);
        chk("single_gnt_done", 32'(bus.gnt), 32'h0);
        chk("single_q", 32'(bus.q), 32'hA5);
        chk("single_carga_done", 32'(bus.carga), 32'h0);
        bus.req = 4'b0000;
        tick();
        chk("single_busy_end", 32'(bus.busy), 32'h0);
        chk("single_ack_end", 32'(bus.ack), 32'h0);
        $display("step single: q=%0h", bus.q);

        // Fairness: reset returns the pointer to 0, then all four request continuously
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        bus.din = 32'h44332211;
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("fair_owner", 32'(bus.owner), 32'(exp_owner[i]));
            chk("fair_gnt", 32'(bus.gnt), 32'(4'b0001 << exp_owner[i]));
            tick();
            chk("fair_carga", 32'(bus.carga), 32'h1);
            tick();
            chk("fair_ack", 32'(bus.ack), 32'(4'b0001 << exp_owner[i]));
            chk("fair_q", 32'(bus.q), 32'(exp_q[i]));
            tick();
            chk("fair_idle", 32'(bus.busy), 32'h0);
            $display("step fairness %0d: owner=%0d q=%0h", i, bus.owner, bus.q);
        end
        bus.req = 4'b0000;

        // Abort: requester 2 drops during GRANT; pointer must stay at 1
        tick();
        bus.req = 4'b0100;
        tick();
        chk("abort_owner", 32'(bus.owner), 32'h2);
        chk("abort_gnt", 32'(bus.gnt), 32'h4);
        bus.req = 4'b0000;
        tick();
        chk("abort_busy", 32'(bus.busy), 32'h0);
        chk("abort_ack", 32'(bus.ack), 32'h0);
        chk("abort_q", 32'(bus.q), 32'h11);
        bus.req = 4'b1010;
        tick();
        chk("abort_ptr_owner", 32'(bus.owner), 32'h1);
        tick();
        tick();
        chk("abort_next_ack", 32'(bus.ack), 32'h2);
        chk("abort_next_q", 32'(bus.q), 32'h22);
        bus.req = 4'b0000;
        tick();
        $display("step abort: owner=%0d q=%0h", bus.owner, bus.q);

        // Asynchronous reset while carga is high
        bus.req = 4'b0001;
        tick();
        tick();
        chk("rload_carga", 32'(bus.carga), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("rload_q", 32'(bus.q), 32'h00);
        chk("rload_gnt", 32'(bus.gnt), 32'h0);
        chk("rload_busy", 32'(bus.busy), 32'h0);
        chk("rload_carga0", 32'(bus.carga), 32'h0);
        tick();
        reset   = 1'b0;
        bus.req = 4'b0000;
        tick();
        chk("rload_ack1", 32'(bus.ack), 32'h0);
        tick();
        chk("rload_ack2", 32'(bus.ack), 32'h0);
        chk("rload_q_after", 32'(bus.q), 32'h00);
        $display("step reset_mid_load: q=%0h", bus.q);

        // Late request from requester 2 during requester 0's LOAD
        bus.req = 4'b0001;
        tick();
        tick();
        bus.req = 4'b0101;
        tick();
        chk("late_ack0", 32'(bus.ack), 32'h1);
        chk("late_owner0", 32'(bus.owner), 32'h0);
        chk("late_q0", 32'(bus.q), 32'h11);
        bus.req = 4'b0100;
        tick();
        chk("late_idle", 32'(bus.busy), 32'h0);
        chk("late_idle_gnt", 32'(bus.gnt), 32'h0);
        tick();
        chk("late_owner2", 32'(bus.owner), 32'h2);
        chk("late_gnt2", 32'(bus.gnt), 32'h4);
        tick();
        tick();
        chk("late_ack2", 32'(bus.ack), 32'h4);
        chk("late_q2", 32'(bus.q), 32'h33);
        bus.req = 4'b0000;
        tick();
        $display("step late: owner=%0d q=%0h", bus.owner, bus.q);

        // Idle stability with changing din
        for (int c = 0; c < 20; c++) begin
            bus.din = $urandom;
            tick();
            chk("idle_q", 32'(bus.q), 32'h33);
            chk("idle_gnt", 32'(bus.gnt), 32'h0);
            chk("idle_ack", 32'(bus.ack), 32'h0);
            chk("idle_carga", 32'(bus.carga), 32'h0);
            chk("idle_busy", 32'(bus.busy), 32'h0);
        end
        $display("step idle: q=%0h", bus.q);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/arbitro_registro.md
ARBITRO_REGISTRO -- requirements
Module: arbitro_registro

Interface
REQ-001 Parameter: W, default 8, width of the shared register and of each requester's data word.
REQ-002 Parameter: N fixed at 4 requesters (not overridable).
REQ-003 Port: clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset; takes effect immediately, independent of clk.
REQ-005 Port: req  input  4  request lines, bit i = requester i; held high until ack[i].
REQ-006 Port: din  input  4*W  requester data, slice i = din[(i+1)*W-1 : i*W].
REQ-007 Port: gnt  output  4  one-hot grant, high only in GRANT and LOAD for the owner.
REQ-008 Port: ack  output  4  one-hot completion pulse, one cycle, in DONE for the owner.
REQ-009 Port: carga  output  1  load enable of the shared register, high only in LOAD.
REQ-010 Port: q  output  W  shared register contents.
REQ-011 Port: owner  output  2  index of current/last granted requester.
REQ-012 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-013 FSM states SHALL be IDLE, GRANT, LOAD, DONE; every state lasts exactly one cycle except IDLE.
REQ-014 IDLE: if any req bit high at the clock edge, SHALL select a winner, register it in owner, go to GRANT; else stay.
REQ-015 Arbitration SHALL be round-robin: search starts at index ptr, then ptr+1, ... modulo 4; first high req wins.
REQ-016 ptr SHALL update to (owner+1) mod 4 on the DONE->IDLE transition only.
REQ-017 GRANT: if req[owner] still high, go to LOAD; if dropped, abort to IDLE with no load, no ack, ptr unchanged.
REQ-018 LOAD: carga=1; at the edge leaving LOAD, q SHALL take din slice [owner]; next state DONE unconditionally.
REQ-019 q SHALL change only at the LOAD->DONE edge or on reset; otherwise it holds.
REQ-020 DONE: ack[owner]=1 for exactly this cycle, gnt=0; next state IDLE unconditionally.
REQ-021 Latency: req sampled high at edge k in IDLE -> gnt at k..k+2, q updated at k+2, ack during k+2..k+3, IDLE after k+3.
REQ-022 Throughput: at most one transfer per 4 cycles; IDLE always occupies at least one cycle between transfers.
REQ-023 req changes of non-owners during GRANT/LOAD/DONE SHALL be ignored until the next IDLE.
REQ-024 A requester still holding req after its ack SHALL be re-arbitrated normally (lowest priority due to ptr).
REQ-025 gnt, ack and carga SHALL be decoded from registered state and owner only (no combinational path from req or din).
REQ-026 gnt and ack SHALL never be high at the same time; at most one bit of each high.

Reset
REQ-027 reset high SHALL immediately force: state IDLE, q=0, gnt=0, ack=0, carga=0, owner=0, busy=0, ptr=0.
REQ-028 reset asserted mid-transfer SHALL abort it: no ack issued, q cleared even if LOAD was active.
REQ-029 reset has priority over every other condition; first arbitration after release starts at index 0.

Verification
REQ-030 Single: W=8, req=0001, din slice0=8'hA5 -> gnt=0001 two cycles, carga one cycle, q=8'hA5, ack=0001 one cycle, busy low after 4 cycles.
REQ-031 Fairness: req=1111 held, ack-then-rerequest -> owners in order 0,1,2,3,0; q follows each slice.
REQ-032 Abort: req=0100 dropped during GRANT -> state IDLE next cycle, q unchanged, ack stays 0000, next arbitration still starts at previous ptr.
REQ-033 Reset mid-LOAD: reset pulse asynchronous while carga=1 -> q=0, gnt=0, busy=0 immediately; no ack after release.
REQ-034 Late request: req=0001 in progress, req[2] rises during LOAD -> ignored until IDLE, then granted (owner=2).
REQ-035 Idle stability: req=0000 for 20 cycles with changing din -> q, gnt, ack, carga constant, busy=0.
